nand_sweep: RTL and testbench
=============================

Name: nand_sweep

Overview:
- Synthesizable, parametrised successor to the fixed 3-input NAND truth-table check.
- Walks every 2^N input pattern of an N-input NAND, one pattern per clock, and drives each pattern to an external device under test (DUT).
- Samples the DUT's result after a configurable latency, compares it to an internal golden NAND reduction, and counts mismatches.
- Used as an on-chip or bench-side exhaustive checker for NAND cells of any width and pipeline depth.

Parameters:
- N, 3, input width of the NAND under test (2..16).
- LAT, 0, DUT latency in clocks from pattern_o to dut_out (0 = combinational DUT, 0..8).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- pattern_o  out  N  current input pattern to the DUT; bit 0 is the LSB input.
- dut_out  in  1  DUT NAND output, valid LAT cycles after the matching pattern_o.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; held until the next start or rst.
- err_count  out  ERR_W  mismatches in the last/current sweep; saturates at all-ones.
- first_fail  out  N  first mismatching pattern (optional feature; otherwise 0).
- first_fail_vld  out  1  first_fail holds a valid capture (optional feature; otherwise 0).

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - state IDLE
  - pattern_o 0, busy 0, done 0, err_count 0
  - first_fail 0, first_fail_vld 0
  - expected/valid delay pipeline cleared
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE --start--> RUN on the next edge:
  - pattern_o = 0, err_count = 0, done = 0, busy = 1.
  - first_fail and first_fail_vld are cleared at the same edge.
- RUN: pattern_o increments by 1 each clock.
  - The terminal condition is pattern_o all-ones; the counter never wraps.
  - At the terminal pattern, the next state is DRAIN if LAT > 0, else DONE.
- DRAIN: pattern_o holds at all-ones for exactly LAT cycles, then the FSM goes to DONE.
- DONE: busy = 0, done = 1; pattern_o holds its last value.
- Sweep duration: busy is high for exactly 2^N + LAT cycles.
- Golden path:
  - expected = ~&pattern_o, computed in sub-module nand_n.
  - expected and a valid bit (1 in RUN) are delayed through a LAT-deep shift register.
  - LAT = 0 means no delay: compare in the same cycle.
- Compare rule: on each cycle where the delayed valid = 1 and dut_out != the delayed expected, err_count increments unless it is all-ones.
- Accounting:
  - Exactly 2^N compares per sweep.
  - The last compare lands on the final RUN cycle (LAT = 0) or the final DRAIN cycle (LAT > 0).
  - err_count is final when done rises.
- start while busy: ignored; the sweep is unaffected.
- rst mid-sweep: immediate return to IDLE at that edge; all outputs take their reset values; no partial result is retained.
- X on dut_out while the delayed valid = 1: counts as a mismatch in simulation (compare with !==); no handling is required in synthesis.

Optional Feature:
- Macro: NAND_SWEEP_FIRST_FAIL_EN.
- Defined:
  - On the first mismatch of a sweep, the pattern that produced it (the delayed copy of pattern_o) is stored in first_fail, and first_fail_vld is set.
  - Later mismatches do not overwrite the capture.
  - Both are cleared on start and on rst.
- Undefined: first_fail and first_fail_vld are tied to 0; no capture registers are built; ports remain present.

Decomposition:
- Package nand_sweep_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE).
  - localparam helpers: NUM_PAT = 2**N, LAT_MAX = 8.
  - function nand_ref(logic [15:0] v, int n), shared with the bench scoreboard.
- Sub-module nand_n (parameter N): combinational golden reduction, out = ~&in. Instantiated once; the bench can reuse it as a behavioural DUT.

Test Plan:
- N=3, LAT=0, DUT = nand_n, pulse start → busy high 8 cycles, done rises, err_count = 0, pattern_o sequence 0..7.
- N=3, LAT=2, DUT = nand_n followed by a 2-flop delay → busy high 10 cycles, err_count = 0.
- N=3, LAT=0, DUT stuck-at-1 → err_count = 1; with macro, first_fail = 3'b111.
- N=3, LAT=1, DUT inverted (AND) → err_count = 8; with macro, first_fail = 0.
- N=6, ERR_W=4, DUT stuck-at-0 → 63 mismatches, err_count saturates at 15; start pulsed mid-sweep is ignored.
- N=3, rst asserted at pattern 4 → next cycle IDLE, pattern_o = 0, err_count = 0, busy = 0, done = 0; a new start then completes normally.

Source files
------------

// File: rtl/nand_sweep_pkg.sv
// nand_sweep_pkg: shared FSM states, limits and golden NAND reference for nand_sweep.
package nand_sweep_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
    localparam int LAT_MAX = 8;
    function automatic int num_pat(int n);
        return 1 << n;
    endfunction
    function automatic logic nand_ref(logic [15:0] v, int n);
        logic a;
        a = 1'b1;
        for (int i = 0; i < 16; i++)
            if (i < n) a &= v[i];
        return ~a;
    endfunction
endpackage

// File: rtl/nand_sweep_nand_n.sv
// nand_n: combinational N-input NAND reduction used as the golden reference.
module nand_n #(
    parameter int N = 3
) (
    input  logic [N-1:0] in,
    output logic         out
);
    assign out = ~&in;
endmodule

// File: rtl/nand_sweep.sv
// nand_sweep: exhaustive N-input NAND checker with a LAT-cycle compare pipeline.
// Define NAND_SWEEP_FIRST_FAIL_EN to capture the first mismatching pattern.
module nand_sweep
    import nand_sweep_pkg::*;
#(
    parameter int N     = 3,
    parameter int LAT   = 0,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N-1:0]     pattern_o,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_count,
    output logic [N-1:0]     first_fail,
    output logic             first_fail_vld
);
    localparam int NUM_PAT = num_pat(N);
    localparam int CW      = $clog2(LAT_MAX + 1);
    state_t        state;
    logic          expected, miss, last, go;
    logic [N+1:0]  cur, dly;
    logic [CW-1:0] drain_cnt;
    nand_n #(.N(N)) u_nand (.in(pattern_o), .out(expected));
    // {valid, expected, pattern} travels together so a mismatch can name its pattern
    assign cur  = {state == RUN, expected, pattern_o};
    assign last = pattern_o == N'(NUM_PAT - 1);
    assign go   = start && (state == IDLE || state == DONE);
    assign miss = dly[N+1] && (dut_out !== dly[N]);
    assign busy = state == RUN || state == DRAIN;
    assign done = state == DONE;
    generate
        if (LAT == 0) begin : g_nodly
            assign dly = cur;
        end else begin : g_dly
            logic [N+1:0] sr [LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= cur;
                    for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
                end
            end
            assign dly = sr[LAT-1];
        end
    endgenerate
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pattern_o <= '0;
            err_count <= '0;
            drain_cnt <= '0;
        end else if (go) begin
            state     <= RUN;
            pattern_o <= '0;
            err_count <= '0;
        end else begin
            if (miss && !(&err_count)) err_count <= err_count + ERR_W'(1);
            if (state == RUN) begin
                pattern_o <= last ? pattern_o : pattern_o + N'(1);
                drain_cnt <= '0;
                if (last) state <= (LAT > 0) ? DRAIN : DONE;
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt + CW'(1);
                if (drain_cnt == CW'(LAT - 1)) state <= DONE;
            end
        end
    end
`ifdef NAND_SWEEP_FIRST_FAIL_EN
    always_ff @(posedge clk) begin
        if (rst || go) begin
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (miss && !first_fail_vld) begin
            first_fail     <= dly[N-1:0];
            first_fail_vld <= 1'b1;
        end
    end
`else
    logic unused_pat;
    assign unused_pat     = ^dly[N-1:0];
    assign first_fail     = '0;
    assign first_fail_vld = 1'b0;
`endif
endmodule

// File: tb/tb_nand_sweep.sv
// tb_nand_sweep: table-driven and randomized checks of three nand_sweep configurations.
module tb_nand_sweep;
    import nand_sweep_pkg::*;
    typedef struct {
        int id;
        int mode;
        int mid;
        int e_err;
        int e_busy;
        int e_ff;
        int e_fv;
    } vec_t;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    logic        start_a [3];
    logic        busy_a  [3];
    logic        done_a  [3];
    logic        fv_a    [3];
    logic [15:0] pat_a   [3];
    logic [15:0] err_a   [3];
    logic [15:0] ff_a    [3];
    logic [63:0] flip_a  [3];
    int np   [3] = '{8, 8, 64};
    int emax [3] = '{255, 255, 15};
    int nb   [3] = '{3, 3, 6};
    int lat  [3] = '{0, 2, 1};
    int vectors = 0;
    int errors  = 0;
    logic [2:0] pat0, pat1, ff0, ff1;
    logic [5:0] pat2, ff2;
    logic [7:0] err0, err1;
    logic [3:0] err2;
    logic       dut0, dut1, dut2, g0, g1, g2, b0, b1, b2, d0, d1, d2, v0, v1, v2;
    logic [1:0] dl1;
    logic       dl2;
    nand_n #(.N(3)) m0 (.in(pat0), .out(g0));
    nand_n #(.N(3)) m1 (.in(pat1), .out(g1));
    nand_n #(.N(6)) m2 (.in(pat2), .out(g2));
    // behavioural DUTs: golden NAND with a per-pattern fault flip, plus latency flops
    assign dut0 = g0 ^ flip_a[0][pat0];
    always @(posedge clk) dl1 <= {dl1[0], g1 ^ flip_a[1][pat1]};
    always @(posedge clk) dl2 <= g2 ^ flip_a[2][pat2];
    assign dut1 = dl1[1];
    assign dut2 = dl2;
    nand_sweep #(.N(3), .LAT(0), .ERR_W(8)) u0 (.clk(clk), .rst(rst), .start(start_a[0]),
        .pattern_o(pat0), .dut_out(dut0), .busy(b0), .done(d0), .err_count(err0),
        .first_fail(ff0), .first_fail_vld(v0));
    nand_sweep #(.N(3), .LAT(2), .ERR_W(8)) u1 (.clk(clk), .rst(rst), .start(start_a[1]),
        .pattern_o(pat1), .dut_out(dut1), .busy(b1), .done(d1), .err_count(err1),
        .first_fail(ff1), .first_fail_vld(v1));
    nand_sweep #(.N(6), .LAT(1), .ERR_W(4)) u2 (.clk(clk), .rst(rst), .start(start_a[2]),
        .pattern_o(pat2), .dut_out(dut2), .busy(b2), .done(d2), .err_count(err2),
        .first_fail(ff2), .first_fail_vld(v2));
    assign busy_a[0] = b0;
    assign busy_a[1] = b1;
    assign busy_a[2] = b2;
    assign done_a[0] = d0;
    assign done_a[1] = d1;
    assign done_a[2] = d2;
    assign fv_a[0]   = v0;
    assign fv_a[1]   = v1;
    assign fv_a[2]   = v2;
    assign pat_a[0]  = 16'(pat0);
    assign pat_a[1]  = 16'(pat1);
    assign pat_a[2]  = 16'(pat2);
    assign err_a[0]  = 16'(err0);
    assign err_a[1]  = 16'(err1);
    assign err_a[2]  = 16'(err2);
    assign ff_a[0]   = 16'(ff0);
    assign ff_a[1]   = 16'(ff1);
    assign ff_a[2]   = 16'(ff2);
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    // mode 0 good, 1 stuck-at-1, 2 inverted (AND), 3 stuck-at-0
    task automatic set_mode(input int id, input int mode);
        logic [63:0] f;
        logic nv;
        f = '0;
        for (int p = 0; p < np[id]; p++) begin
            nv = nand_ref(16'(p), nb[id]);
            f[p] = (mode == 1) ? !nv : (mode == 2) ? 1'b1 : (mode == 3) ? nv : 1'b0;
        end
        flip_a[id] = f;
    endtask
    task automatic sweep(input int id, input int mid, input int e_err, input int e_busy,
                         input int e_ff, input int e_fv);
        int cyc;
        bit seq_ok;
        @(negedge clk);
        start_a[id] = 1'b1;
        @(negedge clk);
        start_a[id] = 1'b0;
        cyc = 0;
        seq_ok = 1'b1;
        while (busy_a[id] === 1'b1 && cyc < 200) begin
            cyc++;
            if (pat_a[id] !== 16'((cyc - 1 < np[id]) ? cyc - 1 : np[id] - 1)) seq_ok = 1'b0;
            start_a[id] = (cyc == mid);
            @(negedge clk);
        end
        start_a[id] = 1'b0;
        chk("busy_cycles", cyc, e_busy);
        chk("pattern_seq", 32'(seq_ok), 1);
        chk("done", 32'(done_a[id]), 1);
        chk("err_count", 32'(err_a[id]), e_err);
`ifdef NAND_SWEEP_FIRST_FAIL_EN
        chk("first_fail", 32'(ff_a[id]), e_ff);
        chk("first_fail_vld", 32'(fv_a[id]), e_fv);
`else
        chk("first_fail", 32'(ff_a[id]), 0);
        chk("first_fail_vld", 32'(fv_a[id]), 0);
`endif
        repeat (3) @(negedge clk);
        chk("done_held", 32'(done_a[id]), 1);
        chk("pattern_hold", 32'(pat_a[id]), np[id] - 1);
    endtask
    vec_t tbl[6];
    initial begin
        int w;
        logic [63:0] f;
        int cnt, first;
        tbl[0] = '{0, 0, -1, 0, 8, 0, 0};
        tbl[1] = '{1, 0, -1, 0, 10, 0, 0};
        tbl[2] = '{0, 1, -1, 1, 8, 7, 1};
        tbl[3] = '{1, 2, -1, 8, 10, 0, 1};
        tbl[4] = '{2, 3, 20, 15, 65, 0, 1};
        tbl[5] = '{2, 0, 5, 0, 65, 0, 0};
        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0;
            flip_a[i]  = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", 32'(busy_a[i]), 0);
            chk("rst_done", 32'(done_a[i]), 0);
            chk("rst_pattern", 32'(pat_a[i]), 0);
            chk("rst_err", 32'(err_a[i]), 0);
            chk("rst_ff", 32'(ff_a[i]), 0);
            chk("rst_fv", 32'(fv_a[i]), 0);
        end
        for (int i = 0; i < 6; i++) begin
            set_mode(tbl[i].id, tbl[i].mode);
            sweep(tbl[i].id, tbl[i].mid, tbl[i].e_err, tbl[i].e_busy, tbl[i].e_ff, tbl[i].e_fv);
        end
        // reset mid-sweep on instance 0 at pattern 4
        set_mode(0, 3);
        @(negedge clk);
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        w = 0;
        while (pat_a[0] !== 16'd4 && w < 20) begin
            w++;
            @(negedge clk);
        end
        chk("reach_pat4", 32'(pat_a[0]), 4);
        chk("err_before_rst", 32'(err_a[0]), 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy_a[0]), 0);
        chk("midrst_done", 32'(done_a[0]), 0);
        chk("midrst_pattern", 32'(pat_a[0]), 0);
        chk("midrst_err", 32'(err_a[0]), 0);
        chk("midrst_fv", 32'(fv_a[0]), 0);
        set_mode(0, 0);
        sweep(0, -1, 0, 8, 0, 0);
        // random fault maps against a counting model
        for (int r = 0; r < 8; r++) begin
            w = $urandom_range(0, 2);
            f = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if (np[w] < 64) f = f & ((64'd1 << np[w]) - 64'd1);
            flip_a[w] = f;
            cnt = 0;
            first = -1;
            for (int p = 0; p < np[w]; p++)
                if (f[p]) begin
                    cnt++;
                    if (first < 0) first = p;
                end
            sweep(w, -1, (cnt > emax[w]) ? emax[w] : cnt, np[w] + lat[w],
                  (first < 0) ? 0 : first, (first < 0) ? 0 : 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
